// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared encodings for the memory stage: funct3 size/sign
//                codes, result-source select codes, and FSM state enum.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

    // funct3 size/sign encodings for loads and stores
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;
    localparam logic [2:0] c_f3_sb  = 3'b000;
    localparam logic [2:0] c_f3_sh  = 3'b001;
    localparam logic [2:0] c_f3_sw  = 3'b010;

    // Write-back result source select
    localparam logic [1:0] c_res_alu = 2'b00;
    localparam logic [1:0] c_res_mem = 2'b01;
    localparam logic [1:0] c_res_pc4 = 2'b10;

    // Memory stage sequencing
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_RD = 1'b1
    } mem_state_e;

    // Size decode: low two funct3 bits give byte/half; anything else is a word
    function automatic logic f3_is_byte(input logic [2:0] f3);
        return (f3[1:0] == 2'b00);
    endfunction

    function automatic logic f3_is_half(input logic [2:0] f3);
        return (f3[1:0] == 2'b01);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic. Store side builds byte enables
//                and replicated write data; load side selects the addressed
//                byte/half and sign- or zero-extends it. Also flags
//                misaligned half/word accesses.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_ctrl,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lane,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic       w_byte;
    logic       w_half;
    logic       w_unsigned;
    logic [7:0] w_sel_byte;
    logic [15:0] w_sel_half;

    // Pick the addressed byte and half out of the returned word
    always_comb begin
        w_sel_byte = load_word[7:0];
        case (addr_lo)
            2'd0: w_sel_byte = load_word[7:0];
            2'd1: w_sel_byte = load_word[15:8];
            2'd2: w_sel_byte = load_word[23:16];
            2'd3: w_sel_byte = load_word[31:24];
            default: w_sel_byte = load_word[7:0];
        endcase
        w_sel_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    assign w_byte     = f3_is_byte(mem_ctrl);
    assign w_half     = f3_is_half(mem_ctrl);
    assign w_unsigned = mem_ctrl[2];

    // Lane steering and extension; unlisted funct3 codes fall to word handling
    always_comb begin
        byte_en    = 4'b1111;
        store_lane = store_data;
        load_data  = load_word;
        misalign   = 1'b0;
        if (w_byte) begin
            byte_en    = 4'b0001 << addr_lo;
            store_lane = {4{store_data[7:0]}};
            load_data  = w_unsigned ? {24'd0, w_sel_byte}
                                    : {{24{w_sel_byte[7]}}, w_sel_byte};
        end else if (w_half) begin
            misalign   = addr_lo[0];
            byte_en    = 4'b0011 << addr_lo;
            store_lane = {2{store_data[15:0]}};
            load_data  = w_unsigned ? {16'd0, w_sel_half}
                                    : {{16{w_sel_half[15]}}, w_sel_half};
        end else begin
            misalign   = (addr_lo != 2'b00);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline memory stage. Issues data-memory requests, stalls
//                the upstream pipe while waiting for grant / read data, and
//                registers the M->W pipeline values (bubble while stalled).
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // M-stage inputs
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [4:0]            RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [2:0]            MemCtrlM,
    // Data memory
    output logic                  DMemReq,
    output logic                  DMemWe,
    output logic [31:0]           DMemAddr,
    output logic [31:0]           DMemWData,
    output logic [3:0]            DMemBe,
    input  logic                  DMemGnt,
    input  logic                  DMemRValid,
    input  logic [31:0]           DMemRData,
    // Hazard
    output logic                  StallM,
    // W-stage outputs
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [4:0]            RdW,
    output logic [DATA_WIDTH-1:0] PCPlus4W,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic                  MisalignW
);

    mem_state_e  r_state;
    logic        w_is_mem;
    logic        w_is_load;
    logic        w_misalign;
    logic        w_req;
    logic        w_stall;
    logic        w_rd_done;
    logic [31:0] w_load_data;

    lsu_align u_lsu_align (
        .addr_lo    (ALUResultM[1:0]),
        .mem_ctrl   (MemCtrlM),
        .store_data (WriteDataM),
        .load_word  (DMemRData),
        .byte_en    (DMemBe),
        .store_lane (DMemWData),
        .load_data  (w_load_data),
        .misalign   (w_misalign)
    );

    // A store wins when both read and write are asserted
    assign w_is_mem  = MemReadM | MemWriteM;
    assign w_is_load = MemReadM & ~MemWriteM;
    assign w_rd_done = (r_state == ST_WAIT_RD) & DMemRValid;

    // Request/stall decode; both forced low while reset is held
    always_comb begin
        w_req   = 1'b0;
        w_stall = 1'b0;
        if (rst_n) begin
            if (r_state == ST_IDLE) begin
                w_req   = w_is_mem & ~w_misalign;
                w_stall = w_req & (~DMemGnt | w_is_load);
            end else begin
                w_stall = ~DMemRValid;
            end
        end
    end

    assign DMemReq  = w_req;
    assign DMemWe   = MemWriteM;
    assign DMemAddr = {ALUResultM[31:2], 2'b00};
    assign StallM   = w_stall;

    // Sequencer: IDLE -> WAIT_RD on a granted load, back on read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_req & DMemGnt & w_is_load) r_state <= ST_WAIT_RD;
                ST_WAIT_RD: if (DMemRValid)                  r_state <= ST_IDLE;
                default:                                     r_state <= ST_IDLE;
            endcase
        end
    end

    // M->W pipeline register; loads a bubble while the stage is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            MisalignW  <= 1'b0;
        end else if (w_stall) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            MisalignW  <= 1'b0;
        end else begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= w_rd_done ? w_load_data : '0;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            RegWriteW  <= RegWriteM & ~(w_is_mem & w_misalign);
            ResultSrcW <= ResultSrcM;
            MisalignW  <= w_is_mem & w_misalign;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM, MemReadM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  MemCtrlM;
    logic        DMemReq, DMemWe, DMemGnt, DMemRValid;
    logic [31:0] DMemAddr, DMemWData, DMemRData;
    logic [3:0]  DMemBe;
    logic        StallM;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW, MisalignW;
    logic [1:0]  ResultSrcW;

    int checks;
    int failures;

    mem_stage #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PCPlus4M   (PCPlus4M),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .MemCtrlM   (MemCtrlM),
        .DMemReq    (DMemReq),
        .DMemWe     (DMemWe),
        .DMemAddr   (DMemAddr),
        .DMemWData  (DMemWData),
        .DMemBe     (DMemBe),
        .DMemGnt    (DMemGnt),
        .DMemRValid (DMemRValid),
        .DMemRData  (DMemRData),
        .StallM     (StallM),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .RdW        (RdW),
        .PCPlus4W   (PCPlus4W),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .MisalignW  (MisalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
        RegWriteM = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0;
        ResultSrcM = 2'b00; MemCtrlM = 3'b000;
        DMemGnt = 1'b0; DMemRValid = 1'b0; DMemRData = '0;
    endtask

    task automatic set_alu(input logic [31:0] res, input logic [4:0] rd);
        set_nop();
        ALUResultM = res; RdM = rd; RegWriteM = 1'b1; PCPlus4M = res + 32'd4;
    endtask

    task automatic test_reset();
        set_nop();
        rst_n = 1'b0;
        MemReadM = 1'b1; MemCtrlM = 3'b010; ALUResultM = 32'h40;
        #12;
        checks++;
        if (StallM !== 1'b0 || DMemReq !== 1'b0) begin
            failures++;
            $display("FAIL reset_req_stall: StallM=%b DMemReq=%b required 0/0", StallM, DMemReq);
        end
        checks++;
        if (ALUResultW !== 32'd0 || RegWriteW !== 1'b0 || RdW !== 5'd0 || MisalignW !== 1'b0 ||
            ReadDataW !== 32'd0 || PCPlus4W !== 32'd0 || ResultSrcW !== 2'd0) begin
            failures++;
            $display("FAIL reset_w: ALUResultW=%h RegWriteW=%b RdW=%0d required all zero", ALUResultW, RegWriteW, RdW);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_alu(32'h55, 5'd9);
        step();
        // Asynchronous assertion mid-cycle must clear W immediately
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ALUResultW !== 32'd0 || RegWriteW !== 1'b0 || RdW !== 5'd0) begin
            failures++;
            $display("FAIL async_reset_w: ALUResultW=%h RegWriteW=%b RdW=%0d required 0", ALUResultW, RegWriteW, RdW);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_nop();
        step();
    endtask

    task automatic test_alu();
        set_alu(32'h10, 5'd5);
        ResultSrcM = 2'b00;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0 || DMemReq !== 1'b0) begin
            failures++;
            $display("FAIL alu_nostall: StallM=%b DMemReq=%b required 0/0", StallM, DMemReq);
        end
        step();
        checks++;
        if (ALUResultW !== 32'h10 || RegWriteW !== 1'b1 || RdW !== 5'd5 ||
            PCPlus4W !== 32'h14 || ReadDataW !== 32'd0 || MisalignW !== 1'b0) begin
            failures++;
            $display("FAIL alu_w: ALUResultW=%h RegWriteW=%b RdW=%0d PCPlus4W=%h ReadDataW=%h required 10/1/5/14/0",
                     ALUResultW, RegWriteW, RdW, PCPlus4W, ReadDataW);
        end
    endtask

    task automatic test_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic also_rd, input int gnt_delay,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_addr);
        set_nop();
        MemWriteM = 1'b1; MemReadM = also_rd; MemCtrlM = f3;
        ALUResultM = addr; WriteDataM = data; RdM = 5'd0;
        for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk);
            checks++;
            if (StallM !== 1'b1 || DMemReq !== 1'b1) begin
                failures++;
                $display("FAIL %s_wait_gnt: StallM=%b DMemReq=%b required 1/1", nm, StallM, DMemReq);
            end
            step();
        end
        DMemGnt = 1'b1;
        @(negedge clk);
        checks++;
        if (DMemReq !== 1'b1 || DMemWe !== 1'b1 || StallM !== 1'b0 || DMemBe !== exp_be ||
            DMemWData !== exp_wd || DMemAddr !== exp_addr) begin
            failures++;
            $display("FAIL %s_bus: Req=%b We=%b Stall=%b Be=%b WData=%h Addr=%h required 1/1/0/%b/%h/%h",
                     nm, DMemReq, DMemWe, StallM, DMemBe, DMemWData, DMemAddr, exp_be, exp_wd, exp_addr);
        end
        step();
        checks++;
        if (ALUResultW !== addr || RegWriteW !== 1'b0 || MisalignW !== 1'b0 || ReadDataW !== 32'd0) begin
            failures++;
            $display("FAIL %s_w: ALUResultW=%h RegWriteW=%b MisalignW=%b ReadDataW=%h required %h/0/0/0",
                     nm, ALUResultW, RegWriteW, MisalignW, ReadDataW, addr);
        end
        set_nop();
    endtask

    task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                             input int gnt_delay, input int rv_delay, input logic [31:0] rdata,
                             input logic [31:0] exp, input int exp_stalls);
        int stalls;
        stalls = 0;
        set_nop();
        MemReadM = 1'b1; MemCtrlM = f3; ALUResultM = addr; RdM = 5'd12;
        RegWriteM = 1'b1; ResultSrcM = 2'b01; PCPlus4M = 32'h800;
        for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk);
            if (StallM === 1'b1) stalls++;
            checks++;
            if (DMemReq !== 1'b1 || DMemWe !== 1'b0 || DMemAddr !== {addr[31:2], 2'b00}) begin
                failures++;
                $display("FAIL %s_req: Req=%b We=%b Addr=%h required 1/0/%h", nm, DMemReq, DMemWe, DMemAddr,
                         {addr[31:2], 2'b00});
            end
            // A stray read-valid before grant must not release the stall
            DMemRValid = 1'b1;
            #1;
            checks++;
            if (StallM !== 1'b1) begin
                failures++;
                $display("FAIL %s_stray_rvalid_idle: StallM=%b required 1", nm, StallM);
            end
            DMemRValid = 1'b0;
            step();
            checks++;
            if (RegWriteW !== 1'b0 || RdW !== 5'd0 || MisalignW !== 1'b0) begin
                failures++;
                $display("FAIL %s_bubble: RegWriteW=%b RdW=%0d required 0/0", nm, RegWriteW, RdW);
            end
        end
        DMemGnt = 1'b1;
        @(negedge clk);
        if (StallM === 1'b1) stalls++;
        checks++;
        if (DMemReq !== 1'b1) begin
            failures++;
            $display("FAIL %s_gnt_req: DMemReq=%b required 1", nm, DMemReq);
        end
        step();
        DMemGnt = 1'b0;
        for (int i = 0; i < rv_delay; i++) begin
            @(negedge clk);
            if (StallM === 1'b1) stalls++;
            checks++;
            if (DMemReq !== 1'b0) begin
                failures++;
                $display("FAIL %s_wait_req: DMemReq=%b required 0", nm, DMemReq);
            end
            step();
        end
        DMemRValid = 1'b1; DMemRData = rdata;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: StallM=%b required 0", nm, StallM);
        end
        step();
        DMemRValid = 1'b0;
        checks++;
        if (ReadDataW !== exp || RegWriteW !== 1'b1 || RdW !== 5'd12 || ResultSrcW !== 2'b01) begin
            failures++;
            $display("FAIL %s_data: ReadDataW=%h RegWriteW=%b RdW=%0d required %h/1/12", nm, ReadDataW,
                     RegWriteW, RdW, exp);
        end
        checks++;
        if (stalls != exp_stalls) begin
            failures++;
            $display("FAIL %s_stall_cycles: counted %0d required %0d", nm, stalls, exp_stalls);
        end
        set_nop();
    endtask

    task automatic test_misalign(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic is_store);
        set_nop();
        MemReadM = ~is_store; MemWriteM = is_store; MemCtrlM = f3;
        ALUResultM = addr; RdM = 5'd7; RegWriteM = ~is_store;
        @(negedge clk);
        checks++;
        if (DMemReq !== 1'b0 || StallM !== 1'b0) begin
            failures++;
            $display("FAIL %s_noreq: DMemReq=%b StallM=%b required 0/0", nm, DMemReq, StallM);
        end
        step();
        checks++;
        if (MisalignW !== 1'b1 || RegWriteW !== 1'b0) begin
            failures++;
            $display("FAIL %s_flag: MisalignW=%b RegWriteW=%b required 1/0", nm, MisalignW, RegWriteW);
        end
        set_nop();
        step();
        checks++;
        if (MisalignW !== 1'b0) begin
            failures++;
            $display("FAIL %s_flag_clear: MisalignW=%b required 0", nm, MisalignW);
        end
    endtask

    task automatic test_reset_in_wait();
        set_nop();
        MemReadM = 1'b1; MemCtrlM = 3'b001; ALUResultM = 32'h100; RdM = 5'd4; RegWriteM = 1'b1;
        DMemGnt = 1'b1;
        step();
        DMemGnt = 1'b0;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b1 || DMemReq !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_entry: StallM=%b DMemReq=%b required 1/0", StallM, DMemReq);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (StallM !== 1'b0 || DMemReq !== 1'b0 || RegWriteW !== 1'b0 || ReadDataW !== 32'd0) begin
            failures++;
            $display("FAIL rst_wait_outputs: StallM=%b DMemReq=%b RegWriteW=%b required 0", StallM, DMemReq,
                     RegWriteW);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_alu(32'h20, 5'd3);
        #1;
        checks++;
        if (StallM !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_idle: StallM=%b required 0", StallM);
        end
        step();
        checks++;
        if (ALUResultW !== 32'h20 || RegWriteW !== 1'b1 || RdW !== 5'd3) begin
            failures++;
            $display("FAIL rst_wait_add: ALUResultW=%h RegWriteW=%b RdW=%0d required 20/1/3", ALUResultW,
                     RegWriteW, RdW);
        end
        set_alu(32'h24, 5'd6);
        DMemRValid = 1'b1; DMemRData = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0) begin
            failures++;
            $display("FAIL rst_stray_stall: StallM=%b required 0", StallM);
        end
        step();
        DMemRValid = 1'b0;
        checks++;
        if (ReadDataW !== 32'd0 || ALUResultW !== 32'h24 || RdW !== 5'd6) begin
            failures++;
            $display("FAIL rst_stray_data: ReadDataW=%h ALUResultW=%h required 0/24", ReadDataW, ALUResultW);
        end
        set_nop();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        set_nop();
        rst_n = 1'b0;
        test_reset();
        test_alu();
        test_store("sb",     3'b000, 32'h103, 32'h0000_00AB, 1'b0, 0, 4'b1000, 32'hABAB_ABAB, 32'h100);
        test_store("sh",     3'b001, 32'h202, 32'h0000_1234, 1'b0, 1, 4'b1100, 32'h1234_1234, 32'h200);
        test_store("sw_rdw", 3'b010, 32'h300, 32'hDEAD_BEEF, 1'b1, 0, 4'b1111, 32'hDEAD_BEEF, 32'h300);
        test_store("sw_111", 3'b111, 32'h304, 32'hCAFE_F00D, 1'b0, 0, 4'b1111, 32'hCAFE_F00D, 32'h304);
        test_load("lb",  3'b000, 32'h101, 2, 3, 32'h0000_80FF, 32'hFFFF_FF80, 6);
        test_load("lbu", 3'b100, 32'h101, 2, 3, 32'h0000_80FF, 32'h0000_0080, 6);
        test_load("lh",  3'b001, 32'h102, 0, 1, 32'h8001_0000, 32'hFFFF_8001, 2);
        test_load("lhu", 3'b101, 32'h102, 0, 0, 32'h8001_0000, 32'h0000_8001, 1);
        test_load("lw",  3'b011, 32'h100, 1, 2, 32'h1234_5678, 32'h1234_5678, 4);
        test_misalign("lw_mis", 3'b010, 32'h102, 1'b0);
        test_misalign("lh_mis", 3'b001, 32'h103, 1'b0);
        test_misalign("sw_mis", 3'b010, 32'h101, 1'b1);
        test_reset_in_wait();
        test_alu();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports clk (in, 1, rising-edge clock) and rst_n (in, 1, async active-low reset), listed first.
REQ-003 The block SHALL have these M-stage inputs: ALUResultM in DATA_WIDTH (address/ALU result); WriteDataM in DATA_WIDTH (store data); RdM in 5 (destination register); PCPlus4M in DATA_WIDTH (link value); RegWriteM in 1; ResultSrcM in 2; MemWriteM in 1; MemReadM in 1; MemCtrlM in 3 (funct3 size/sign).
REQ-004 The block SHALL have these data-memory ports: DMemReq out 1 (request); DMemWe out 1 (write); DMemAddr out 32 (word-aligned address); DMemWData out 32 (lane-shifted data); DMemBe out 4 (byte enables); DMemGnt in 1 (request accepted); DMemRValid in 1 (read data valid); DMemRData in 32 (read word).
REQ-005 The block SHALL have a hazard output: StallM out 1 (hold the F/D/E/M stages).
REQ-006 The block SHALL have these W-stage outputs: ALUResultW out DATA_WIDTH; ReadDataW out DATA_WIDTH; RdW out 5; PCPlus4W out DATA_WIDTH; RegWriteW out 1; ResultSrcW out 2; MisalignW out 1 (misaligned access flag).

Function
REQ-007 A memory op SHALL be MemReadM|MemWriteM; MemReadM and MemWriteM both high SHALL be treated as a store.
REQ-008 A non-memory op SHALL pass to the W outputs at the next rising edge (1-cycle latency), with StallM=0.
REQ-009 The FSM SHALL have two states, IDLE and WAIT_RD.
REQ-010 In IDLE, for an aligned memory op, DMemReq SHALL be driven combinationally; DMemAddr={ALUResultM[31:2],2'b00}; DMemWe=MemWriteM.
REQ-011 On a store with DMemGnt=1 in IDLE, the store SHALL complete: StallM=0, and W updates at the edge.
REQ-012 On a load with DMemGnt=1 in IDLE, the FSM SHALL go to WAIT_RD, with StallM=1 that cycle.
REQ-013 In IDLE with DMemGnt=0, the FSM SHALL stay in IDLE with StallM=1 and DMemReq held; upstream holds the M inputs stable while StallM=1.
REQ-014 In WAIT_RD, DMemReq SHALL be 0 and StallM SHALL be 1 until DMemRValid=1; then StallM=0, the aligned/extended data SHALL be registered into ReadDataW, and the FSM SHALL return to IDLE.
REQ-015 DMemRValid outside WAIT_RD SHALL be ignored, and DMemRValid SHALL never be expected in the same cycle as DMemGnt.
REQ-016 While StallM=1, the W register SHALL load a bubble: RegWriteW=0, RdW=0, MisalignW=0.
REQ-017 Store lanes: SB shall use Be=0001<<a[1:0] with byte replicated; SH shall use Be=0011<<a[1:0] with half replicated; SW shall use Be=1111.
REQ-018 Loads SHALL select the byte/half at a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through; MemCtrlM 011/110/111 SHALL be treated as LW/SW.
REQ-019 A misaligned access (half with a[0]=1, word with a[1:0]!=0) SHALL issue no DMemReq; it completes in 1 cycle with MisalignW=1 and RegWriteW=0.
REQ-020 For a non-load, ReadDataW SHALL be 0.

Reset
REQ-021 rst_n low SHALL set the FSM to IDLE and set all W outputs to 0 asynchronously; StallM and DMemReq SHALL be 0 while rst_n=0.
REQ-022 A reset in WAIT_RD SHALL abandon the load; a late DMemRValid SHALL be ignored per REQ-015.

Structure
REQ-023 A shared package SHALL hold the MemCtrl funct3 encodings, the ResultSrc encodings and the FSM state enum.
REQ-024 The combinational lane logic SHALL be one sub-module, lsu_align, covering the store Be/data shift and the load select/extend.

Verification
REQ-025 ADD, ALUResultM=0x10 -> ALUResultW=0x10 and RegWriteW=1 next edge, StallM=0 throughout.
REQ-026 SB addr 0x103, data 0xAB, Gnt=1 -> DMemBe=1000, DMemWData=0xABABABAB, DMemAddr=0x100, single cycle.
REQ-027 LB addr 0x101, Gnt after 2 cycles, RValid 3 cycles later with RData=0x0000_80FF -> StallM=1 for 6 cycles, bubbles in W, then ReadDataW=0xFFFF_FF80 (0x80 sign-extended); LBU -> 0x0000_0080.
REQ-028 LW addr 0x102 -> DMemReq stays 0, MisalignW=1, RegWriteW=0 next edge.
REQ-029 LH in WAIT_RD, rst_n pulsed low, then stray RValid -> all outputs 0, IDLE, RValid ignored, next ADD completes normally.
